// File: rtl/led_trail_pwm_if.sv
// LED trail PWM bus: chaser request pattern in, LED pins and frame strobe out.
// The chaser side is the master; the PWM output stage is the slave.
interface led_trail_pwm_if;
    logic [5:0] pattern_n;
    logic [5:0] leds;
    logic       frame;

    modport master (
        output pattern_n,
        input  leds,
        input  frame
    );

    modport slave (
        input  pattern_n,
        output leds,
        output frame
    );
endinterface

// File: rtl/led_trail_pwm.sv
// Six-channel active-low LED PWM stage with linear fade-out comet trail.
// Optional macro LED_GAMMA_EN squares the level into a registered duty.
module led_trail_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 27000000 / 256,
    parameter int FADE_STEP = 4
) (
    input logic           sys_clk,
    input logic           sys_reset,
    led_trail_pwm_if.slave bus
);

    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FW-1:0]       fade_cnt;
    logic                fade_tick;
    logic [PWM_BITS-1:0] level [6];
    logic [PWM_BITS-1:0] faded [6];
    logic [PWM_BITS-1:0] duty  [6];

    assign fade_tick = (fade_cnt == FADE_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            pwm_cnt   <= '0;
            fade_cnt  <= '0;
            bus.frame <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            fade_cnt  <= fade_tick ? '0 : fade_cnt + 1'b1;
            bus.frame <= &pwm_cnt;
        end
    end

    // One bit of headroom keeps the subtraction from wrapping below zero.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            faded[i] = '0;
            if ({1'b0, level[i]} > STEP_W)
                faded[i] = level[i] - STEP_W[PWM_BITS-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            for (int i = 0; i < 6; i++)
                level[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!bus.pattern_n[i])
                    level[i] <= MAX;
                else if (fade_tick)
                    level[i] <= faded[i];
            end
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq [6];

    always_comb begin
        for (int i = 0; i < 6; i++)
            sq[i] = {{PWM_BITS{1'b0}}, level[i]}
                  * {{PWM_BITS{1'b0}}, level[i]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            for (int i = 0; i < 6; i++)
                duty[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++)
                duty[i] <= sq[i][2*PWM_BITS-1:PWM_BITS];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 6; i++)
            duty[i] = level[i];
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            bus.leds <= 6'b111111;
        end else begin
            for (int i = 0; i < 6; i++)
                bus.leds[i] <= ~(duty[i] > pwm_cnt);
        end
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Randomized bench for led_trail_pwm against a cycle-history model.
// Two instances share stimulus: fade step 3 and fade step 4.
module tb_led_trail_pwm;

    localparam int PB  = 4;
    localparam int FD  = 4;
    localparam int ST  = 3;
    localparam int ST2 = 4;
    localparam int M   = 15;
    localparam int P   = 16;

    logic       sys_clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic [5:0] pat = 6'h3f;

    always #5 sys_clk = ~sys_clk;

    led_trail_pwm_if bus_a ();
    led_trail_pwm_if bus_b ();

    assign bus_a.pattern_n = pat;
    assign bus_b.pattern_n = pat;

    led_trail_pwm #(.PWM_BITS(PB), .FADE_DIV(FD), .FADE_STEP(ST)) dut_a (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .bus       (bus_a.slave)
    );

    led_trail_pwm #(.PWM_BITS(PB), .FADE_DIV(FD), .FADE_STEP(ST2)) dut_b (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .bus       (bus_b.slave)
    );

    int passed = 0;
    int total  = 0;

    // Model: k = cycle index since the last reset edge,
    // lv[d][age][i] = level of LED i in cycle k-age.
    int k = 0;
    bit mvalid = 0;
    int lv [2][3][6];
    int steps [2] = '{ST, ST2};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)",
                      name, act, exp, k);
    endtask

    task automatic model_update();
        bit tick;
        if (sys_reset) begin
            k = 0;
            mvalid = 1;
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 3; a++)
                    for (int i = 0; i < 6; i++)
                        lv[d][a][i] = 0;
        end else begin
            tick = ((k % FD) == FD - 1);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 6; i++) begin
                    lv[d][2][i] = lv[d][1][i];
                    lv[d][1][i] = lv[d][0][i];
                    if (!pat[i])
                        lv[d][0][i] = M;
                    else if (tick)
                        lv[d][0][i] = (lv[d][0][i] > steps[d])
                                    ? lv[d][0][i] - steps[d] : 0;
                end
            end
            k++;
        end
    endtask

    function automatic logic [5:0] exp_leds(input int d);
        logic [5:0] e;
        int du;
        e = 6'h3f;
        if (k > 0) begin
            for (int i = 0; i < 6; i++) begin
`ifdef LED_GAMMA_EN
                du = (lv[d][2][i] * lv[d][2][i]) >> PB;
`else
                du = lv[d][1][i];
`endif
                e[i] = !(du > ((k - 1) % P));
            end
        end
        return e;
    endfunction

    function automatic logic exp_frame();
        return (k >= 1) && (((k - 1) % P) == P - 1);
    endfunction

    task automatic step(input logic [5:0] p, input logic r);
        pat = p;
        sys_reset = r;
        @(posedge sys_clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (mvalid) begin
                check("leds_a", int'(bus_a.leds), int'(exp_leds(0)));
                check("leds_b", int'(bus_b.leds), int'(exp_leds(1)));
                check("frame_a", int'(bus_a.frame), int'(exp_frame()));
                check("frame_b", int'(bus_b.frame), int'(exp_frame()));
            end
        end
    end

    int first;
    int low0;
    int hi;
    int frames;
    int prev;
    int seq_a[$];
    int seq_b[$];
    int prev_b;
    bit found;
    logic [5:0] rp;
    int hold;

    initial begin
        step(6'h3f, 1'b1);
        check("reset_leds", int'(bus_a.leds), 63);
        check("reset_frame", int'(bus_a.frame), 0);

        first = -1;
        for (int c = 0; c < 20; c++) begin
            if (first < 0 && bus_a.frame) first = k;
            step(6'h3f, 1'b0);
        end
        check("first_frame", first, 16);

        for (int c = 0; c < 40; c++) step(6'h3e, 1'b0);
        low0 = 0; hi = 0; frames = 0;
        for (int c = 0; c < 32; c++) begin
            if (c < 16 && !bus_a.leds[0]) low0++;
            if (bus_a.leds[5:1] == 5'h1f) hi++;
            if (bus_a.frame) frames++;
            step(6'h3e, 1'b0);
        end
        check("hold_low_count", low0, 15);
        check("hold_others_high", hi, 32);
        check("hold_frames", frames, 2);

        seq_a.delete(); seq_b.delete();
        prev = lv[0][0][0]; prev_b = lv[1][0][0];
        seq_a.push_back(prev); seq_b.push_back(prev_b);
        for (int c = 0; c < 40; c++) begin
            step(6'h3f, 1'b0);
            if (lv[0][0][0] != prev) begin
                prev = lv[0][0][0];
                seq_a.push_back(prev);
            end
            if (lv[1][0][0] != prev_b) begin
                prev_b = lv[1][0][0];
                seq_b.push_back(prev_b);
            end
        end
        check("fade_seq_len_a", seq_a.size(), 6);
        if (seq_a.size() == 6) begin
            check("fade_a0", seq_a[0], 15);
            check("fade_a1", seq_a[1], 12);
            check("fade_a3", seq_a[3], 6);
            check("fade_a5", seq_a[5], 0);
        end
        check("fade_seq_len_b", seq_b.size(), 5);
        if (seq_b.size() == 5) begin
            check("sat_b1", seq_b[1], 11);
            check("sat_b3", seq_b[3], 3);
            check("sat_b4", seq_b[4], 0);
        end
        hi = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus_a.leds[0]) hi++;
            step(6'h3f, 1'b0);
        end
        check("dark_after_fade", hi, 16);

        for (int c = 0; c < 8; c++) step(6'h3e, 1'b0);
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if ((k % FD) == FD - 1 && lv[0][0][0] == 6) begin
                found = 1;
                step(6'h3e, 1'b0);
                check("reassert_level", lv[0][0][0], 15);
            end else begin
                step(6'h3f, 1'b0);
            end
        end
        check("reassert_found", int'(found), 1);
        for (int c = 0; c < 20; c++) step(6'h3e, 1'b0);

        for (int c = 0; c < 7; c++) step(6'h3d, 1'b0);
        step(6'h3d, 1'b1);
        check("midreset_leds", int'(bus_a.leds), 63);
        check("midreset_frame", int'(bus_a.frame), 0);
        first = -1;
        for (int c = 0; c < 20; c++) begin
            if (first < 0 && bus_a.frame) first = k;
            step(6'h3d, 1'b0);
        end
        check("midreset_first_frame", first, 16);

        rp = 6'h3e;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0)
                    rp = 6'($urandom);
                else
                    rp = ~(6'b1 << $urandom_range(0, 5));
                if ($urandom_range(0, 4) == 0) rp = 6'h3f;
                hold = $urandom_range(1, 40);
            end
            hold--;
            step(rp, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        step(6'h3f, 1'b0);
        @(negedge sys_clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
